// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster-scan 3x3 window generator built around two external
// line-buffer RAMs (depth IMG_W, 1-cycle read latency).
// Pixel flow: acceptance (t) -> lb0 read/write; t+1 -> lb1 read/write;
// t+2 -> column shifted into the tap array; t+3 -> window out.
// Optional feature: define WINDOW_STRIDE2_EN to emit only every other window
// in both row and column (stride 2).
module window_gen_3x3 #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 10,
    parameter int IMG_H      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    lb0_wr_en,
    output logic                    lb0_rd_en,
    output logic [DATA_WIDTH-1:0]   lb0_din,
    input  logic [DATA_WIDTH-1:0]   lb0_dout,
    output logic                    lb1_wr_en,
    output logic                    lb1_rd_en,
    output logic [DATA_WIDTH-1:0]   lb1_din,
    input  logic [DATA_WIDTH-1:0]   lb1_dout,
    output logic                    win_valid,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_col;
    logic          last_row;

    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));

    // Stage-0 qualifiers describing the pixel being accepted this cycle.
    logic s0_r1;
    logic s0_r2;
    logic s0_emit;
    logic s0_last;

    assign s0_r1 = (row != '0);
    assign s0_r2 = (row >= RW'(2));

`ifdef WINDOW_STRIDE2_EN
    // Last emitted window ends on the largest even row/col index in range.
    localparam int LAST_R = ((IMG_H - 1) % 2 == 0) ? IMG_H - 1 : IMG_H - 2;
    localparam int LAST_C = ((IMG_W - 1) % 2 == 0) ? IMG_W - 1 : IMG_W - 2;
    assign s0_emit = s0_r2 && (col >= CW'(2)) && !row[0] && !col[0];
    assign s0_last = (row == RW'(LAST_R)) && (col == CW'(LAST_C));
`else
    assign s0_emit = s0_r2 && (col >= CW'(2));
    assign s0_last = last_row && last_col;
`endif

    // Line buffer 0 is driven straight from the input so it sees the pixel
    // in its acceptance cycle; forced low while in reset.
    assign lb0_wr_en = in_valid & ~rst;
    assign lb0_rd_en = in_valid & s0_r1 & ~rst;
    assign lb0_din   = lb0_wr_en ? in_data : '0;

    // Raster position of the next accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    logic                  s1_valid;
    logic                  s1_r1;
    logic                  s1_r2;
    logic                  s1_emit;
    logic                  s1_last;
    logic [DATA_WIDTH-1:0] s1_data;

    // Stage 1: pixel one cycle after acceptance, lb0 read data now on lb0_dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r1    <= 1'b0;
            s1_r2    <= 1'b0;
            s1_emit  <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_r1    <= s0_r1;
            s1_r2    <= s0_r2;
            s1_emit  <= s0_emit;
            s1_last  <= s0_last;
            s1_data  <= in_data;
        end
    end

    // Row r-1 pixel read from lb0 is pushed into lb1, which then holds row r-2.
    assign lb1_wr_en = s1_valid & s1_r1;
    assign lb1_rd_en = s1_valid & s1_r2;
    assign lb1_din   = lb1_wr_en ? lb0_dout : '0;

    logic                  s2_valid;
    logic                  s2_emit;
    logic                  s2_last;
    logic [DATA_WIDTH-1:0] s2_mid;
    logic [DATA_WIDTH-1:0] s2_bot;

    // Stage 2: align rows r (input) and r-1 (lb0) with row r-2 arriving from lb1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_emit  <= 1'b0;
            s2_last  <= 1'b0;
            s2_mid   <= '0;
            s2_bot   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_emit  <= s1_emit;
            s2_last  <= s1_last;
            s2_mid   <= lb0_dout;
            s2_bot   <= s1_data;
        end
    end

    // taps[3*i+j]: row i (0 = oldest), column j (2 = newest).
    logic [DATA_WIDTH-1:0] taps [0:8];

    // Shift the new column into the tap array only when a pixel is present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) taps[k] <= '0;
        end else if (s2_valid) begin
            for (int i = 0; i < 3; i++) begin
                taps[3*i]   <= taps[3*i+1];
                taps[3*i+1] <= taps[3*i+2];
            end
            taps[2] <= lb1_dout;
            taps[5] <= s2_mid;
            taps[8] <= s2_bot;
        end
    end

    // Window qualifiers registered alongside the tap update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= s2_valid & s2_emit;
            frame_done <= s2_valid & s2_last;
        end
    end

    // Flatten the tap array onto the window bus.
    always_comb begin
        win_data = '0;
        for (int k = 0; k < 9; k++) win_data[DATA_WIDTH*k +: DATA_WIDTH] = taps[k];
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 with behavioural line-buffer RAMs.
module tb_window_gen_3x3;

    localparam int DW = 16;
    localparam int W  = 10;
    localparam int H  = 10;
`ifdef WINDOW_STRIDE2_EN
    localparam int WPF = ((H - 1) / 2) * ((W - 1) / 2);
`else
    localparam int WPF = (H - 2) * (W - 2);
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          lb0_wr_en, lb0_rd_en, lb1_wr_en, lb1_rd_en;
    logic [DW-1:0] lb0_din, lb0_dout, lb1_din, lb1_dout;
    logic          win_valid, frame_done;
    logic [9*DW-1:0] win_data;

    window_gen_3x3 #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .lb0_wr_en(lb0_wr_en), .lb0_rd_en(lb0_rd_en), .lb0_din(lb0_din), .lb0_dout(lb0_dout),
        .lb1_wr_en(lb1_wr_en), .lb1_rd_en(lb1_rd_en), .lb1_din(lb1_din), .lb1_dout(lb1_dout),
        .win_valid(win_valid), .win_data(win_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line-buffer RAM models: circular, independent read/write pointers,
    // read-first, 1-cycle read latency, reset together with the DUT.
    logic [DW-1:0] mem0 [0:W-1];
    logic [DW-1:0] mem1 [0:W-1];
    int wp0, rp0, wp1, rp1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp0 <= 0; rp0 <= 0; wp1 <= 0; rp1 <= 0;
            lb0_dout <= '0; lb1_dout <= '0;
        end else begin
            if (lb0_rd_en) begin lb0_dout <= mem0[rp0]; rp0 <= (rp0 + 1) % W; end
            if (lb0_wr_en) begin mem0[wp0] <= lb0_din;  wp0 <= (wp0 + 1) % W; end
            if (lb1_rd_en) begin lb1_dout <= mem1[rp1]; rp1 <= (rp1 + 1) % W; end
            if (lb1_wr_en) begin mem1[wp1] <= lb1_din;  wp1 <= (wp1 + 1) % W; end
        end
    end

    typedef struct {
        logic [9*DW-1:0] data;
        logic            fd;
        int              cyc;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    int win_count = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [9*DW-1:0] make_win(input int base, input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[DW*(3*i+j) +: DW] = DW'(base + 10*(r-2+i) + (c-2+j));
        return w;
    endfunction

    // One input cycle; a valid pixel at (r,c) queues its expected window.
    task automatic drive(input bit v, input int base, input int r, input int c);
        bit emit, last;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = v ? DW'(base + 10*r + c) : DW'($urandom);
        if (v) begin
`ifdef WINDOW_STRIDE2_EN
            emit = (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
            last = (r == (((H-1) % 2 == 0) ? H-1 : H-2)) && (c == (((W-1) % 2 == 0) ? W-1 : W-2));
`else
            emit = (r >= 2) && (c >= 2);
            last = (r == H-1) && (c == W-1);
`endif
            if (emit) begin
                e.data = make_win(base, r, c);
                e.fd   = last;
                e.cyc  = cyc + 3;
                q.push_back(e);
            end
        end
        @(negedge clk);
        check("lb0_wr_en", lb0_wr_en, v);
        check("lb0_rd_en", lb0_rd_en, v && (r >= 1));
        if (v) check("lb0_din", lb0_din, in_data);
    endtask

    task automatic send_frame(input int base, input bit gaps, input int stop_k);
        for (int k = 0; k < W*H; k++) begin
            if (k == stop_k) return;
            if (gaps) drive(0, base, 0, 0);
            drive(1, base, k / W, k % W);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    task automatic end_section(input string tag, input int exp_count);
        idle(6);
        check({tag, "_count"}, win_count, exp_count);
        check({tag, "_queue_empty"}, q.size(), 0);
        win_count = 0;
    endtask

    // Output monitor: every window must match the head of the scoreboard on time.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (win_valid) begin
                if (q.size() == 0) begin
                    check("win_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("win_data", win_data, e.data);
                    check("frame_done", frame_done, e.fd);
                    check("win_latency", cyc, e.cyc);
                    win_count++;
                end
            end else if (frame_done) begin
                check("frame_done_alone", 1, 0);
            end
            while (q.size() > 0 && cyc > q[0].cyc) begin
                check("win_missing", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        // Reset held 3 cycles with in_valid toggling: every output must be 0.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i % 2 == 0);
            in_data  = DW'($urandom);
            @(negedge clk);
            check("reset_outputs",
                  {lb0_wr_en, lb0_rd_en, lb0_din, lb1_wr_en, lb1_rd_en, lb1_din,
                   win_valid, win_data, frame_done}, '0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;

        // Ramp frame, continuous valid.
        send_frame(0, 0, -1);
        end_section("frame_cont", WPF);

        // Same frame with a bubble before every pixel.
        send_frame(0, 1, -1);
        end_section("frame_gaps", WPF);

        // Two frames back to back.
        send_frame(0, 0, -1);
        send_frame(100, 0, -1);
        end_section("two_frames", 2*WPF);

        // Reset in the cycle pixel (4,5) would be offered, then a full frame.
        send_frame(0, 0, 4*W + 5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b1;
        q.delete();
        win_count = 0;
        @(negedge clk);
        check("midreset_win_valid", win_valid, 0);
        check("midreset_lb0_wr_en", lb0_wr_en, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(0, 0, -1);
        end_section("after_reset", WPF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
